access_arbiter: RTL

- Shares the single password-checked even/odd access datapath among NREQ requesters using round-robin arbitration.
- Grants one requester at a time and waits for its confirm. Verifies the submitted password against the stored one, then drives evenEnable/oddEnable from bit 0 of that requester's data.
- Counts consecutive password failures and locks the resource for a fixed interval after MAX_FAIL failures.
- Sits between the user-input front end and the even/odd enable consumers.

---
 rtl/access_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/access_arbiter.sv
// access_arbiter: round-robin front end for the password-checked
// even/odd access datapath, with failure lockout and confirm timeout.
module access_arbiter #(
  parameter int NREQ         = 4,
  parameter int PW_W         = 4,
  parameter int DATA_W       = 4,
  parameter int MAX_FAIL     = 3,
  parameter int LOCK_CYCLES  = 16,
  parameter int CONF_TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              confirm,
  input  logic [NREQ*PW_W-1:0]         pw_in,
  input  logic [NREQ*DATA_W-1:0]       data_in,
  input  logic [PW_W-1:0]              password,
  output logic [NREQ-1:0]              grant,
  output logic                         evenEnable,
  output logic                         oddEnable,
  output logic                         deny,
  output logic                         locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCK_CYCLES > CONF_TIMEOUT) ?
                        LOCK_CYCLES : CONF_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CONF,
    CHECK,
    SERVE,
    LOCKOUT
  } state_t;

  state_t        state, stateN;
  logic [IW-1:0] gIdx, gIdxN;
  logic [IW-1:0] ptr, ptrN;
  logic [TW-1:0] timer, timerN;
  logic [PW_W-1:0] pwQ, pwN;
  logic          dataBit, dataBitN;
  logic [FW-1:0] failQ, failN;
  logic          denyQ, denyN;

  logic [IW-1:0] pick;
  logic [IW-1:0] nextPtr;
  logic [FW-1:0] failInc;
  int            cand;

  // Descending scan so the smallest offset from ptr wins.
  always_comb begin
    pick = '0;
    cand = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) pick = IW'(cand);
    end
  end

  assign nextPtr = (gIdx == IW'(NREQ - 1)) ? '0 : IW'(gIdx + 1'b1);
  assign failInc = failQ + 1'b1;

  always_comb begin
    stateN   = state;
    gIdxN    = gIdx;
    ptrN     = ptr;
    timerN   = timer;
    pwN      = pwQ;
    dataBitN = dataBit;
    failN    = failQ;
    denyN    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gIdxN  = pick;
          timerN = '0;
          stateN = WAIT_CONF;
        end
      end
      WAIT_CONF: begin
        if (!req[gIdx]) begin
          ptrN   = nextPtr;
          stateN = IDLE;
        end else if (confirm[gIdx]) begin
          pwN      = pw_in[int'(gIdx)*PW_W +: PW_W];
          dataBitN = data_in[int'(gIdx)*DATA_W];
          stateN   = CHECK;
        end else if (timer == TW'(CONF_TIMEOUT - 1)) begin
          ptrN   = nextPtr;
          stateN = IDLE;
        end else begin
          timerN = timer + 1'b1;
        end
      end
      CHECK: begin
        if (pwQ == password) begin
          failN  = '0;
          stateN = SERVE;
        end else begin
          denyN  = 1'b1;
          failN  = failInc;
          ptrN   = nextPtr;
          timerN = '0;
          stateN = (failInc == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
        end
      end
      SERVE: begin
        if (!req[gIdx]) begin
          ptrN   = nextPtr;
          stateN = IDLE;
        end
      end
      LOCKOUT: begin
        if (timer == TW'(LOCK_CYCLES - 1)) begin
          failN  = '0;
          stateN = IDLE;
        end else begin
          timerN = timer + 1'b1;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gIdx    <= '0;
      ptr     <= '0;
      timer   <= '0;
      pwQ     <= '0;
      dataBit <= 1'b0;
      failQ   <= '0;
      denyQ   <= 1'b0;
    end else begin
      state   <= stateN;
      gIdx    <= gIdxN;
      ptr     <= ptrN;
      timer   <= timerN;
      pwQ     <= pwN;
      dataBit <= dataBitN;
      failQ   <= failN;
      denyQ   <= denyN;
    end
  end

  always_comb begin
    grant = '0;
    if (state == WAIT_CONF || state == CHECK || state == SERVE)
      grant[gIdx] = 1'b1;
  end

  assign evenEnable = (state == SERVE) && !dataBit;
  assign oddEnable  = (state == SERVE) && dataBit;
  assign locked     = (state == LOCKOUT);
  assign deny       = denyQ;
  assign fail_count = failQ;

endmodule
